mmio_periph_resp: RTL

Memory-mapped peripheral responder on the miniRV SoC data bus: the target side of the CPU load/store interface for addresses in the I/O window. It holds the LED and 7-segment registers, a free-running timer, and synchronized switch and debounced button inputs. It drives the 8-digit scanned 7-segment display. The SoC uses `hit` to choose between its `rdata` and DRAM read data, and to gate the DRAM write enable.

---
 rtl/mmio_pkg.sv | 37 +++
 rtl/seg7_scan.sv | 41 ++++
 rtl/mmio_periph_resp.sv | 132 +++++++++++++
 3 files changed

// File: rtl/mmio_pkg.sv
// rtl/mmio_pkg.sv - shared constants and glyph table for the MMIO peripheral responder
// Contents: I/O window base, register offsets, hex_to_seg (4-bit nibble -> active-low {G..A}).
package mmio_pkg;

    localparam logic [19:0] IO_BASE   = 20'hFFFFF;

    localparam logic [11:0] OFF_DIG   = 12'h000;
    localparam logic [11:0] OFF_TIMER = 12'h020;
    localparam logic [11:0] OFF_LED   = 12'h060;
    localparam logic [11:0] OFF_SW    = 12'h070;
    localparam logic [11:0] OFF_BTN   = 12'h078;

    // Standard hex glyphs, segment lines active-low, packed {G,F,E,D,C,B,A}.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg7_scan.sv
// rtl/seg7_scan.sv - eight-digit multiplexed 7-segment scanner
// Ports: clk/rst (async active-high), i_dig (eight hex nibbles, nibble k on digit k),
//        o_dig_en (active-low one-cold digit enable), o_seg ({G..A}, active-low), o_dp (always off).
module seg7_scan
    import mmio_pkg::*;
#(
    parameter int SCAN_DIV = 20000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_dig,
    output logic [7:0]  o_dig_en,
    output logic [6:0]  o_seg,
    output logic        o_dp
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [DIV_W-1:0] r_div;
    logic [2:0]       r_idx;
    logic [3:0]       w_nib;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div <= '0;
            r_idx <= '0;
        end else if (r_div == DIV_W'(SCAN_DIV - 1)) begin
            r_div <= '0;
            r_idx <= r_idx + 3'd1;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    // Glyph is combinational from the DIG register so a store shows on the next cycle.
    assign w_nib    = i_dig[{r_idx, 2'b00} +: 4];
    assign o_dig_en = ~(8'b1 << r_idx);
    assign o_seg    = hex_to_seg(w_nib);
    assign o_dp     = 1'b1;

endmodule

// File: rtl/mmio_periph_resp.sv
// rtl/mmio_periph_resp.sv - I/O-window target on the CPU data bus (DIG, TIMER, LED, SW, BTN)
// Ports: cpu_clk/cpu_rst (async active-high); addr/we/wdata/rdata/hit CPU data port;
//        sw/button raw inputs; led register; dig_en + DN_* scanned display (active-low).
module mmio_periph_resp
    import mmio_pkg::*;
#(
    parameter int SCAN_DIV  = 20000,
    parameter int DB_CYCLES = 250000
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        hit,
    input  logic [23:0] sw,
    input  logic [4:0]  button,
    output logic [23:0] led,
    output logic [7:0]  dig_en,
    output logic        DN_A,
    output logic        DN_B,
    output logic        DN_C,
    output logic        DN_D,
    output logic        DN_E,
    output logic        DN_F,
    output logic        DN_G,
    output logic        DN_DP
);

    localparam int DB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

    logic [31:0] r_dig;
    logic [31:0] r_timer;
    logic [23:0] r_led;
    logic [23:0] r_sw_s1, r_sw_s2;
    logic [4:0]  r_btn_s1, r_btn_s2;
    logic [4:0]  w_btn_db;
    logic [11:0] w_off;
    logic        w_wr;
    logic [31:0] w_rdata;
    logic [6:0]  w_seg;

    assign hit   = (addr[31:12] == IO_BASE);
    assign w_off = addr[11:0];
    assign w_wr  = we && hit;

    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            r_dig <= '0;
            r_led <= '0;
        end else if (w_wr) begin
            if (w_off == OFF_DIG) r_dig <= wdata;
            if (w_off == OFF_LED) r_led <= wdata[23:0];
        end
    end

    // A store to TIMER takes priority over that cycle's increment.
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst)                      r_timer <= '0;
        else if (w_wr && w_off == OFF_TIMER) r_timer <= wdata;
        else                              r_timer <= r_timer + 32'd1;
    end

    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            r_sw_s1  <= '0;
            r_sw_s2  <= '0;
            r_btn_s1 <= '0;
            r_btn_s2 <= '0;
        end else begin
            r_sw_s1  <= sw;
            r_sw_s2  <= r_sw_s1;
            r_btn_s1 <= button;
            r_btn_s2 <= r_btn_s1;
        end
    end

    // Counter runs only while the synced input disagrees with the debounced value;
    // any return to agreement restarts it, so short glitches never propagate.
    for (genvar g = 0; g < 5; g++) begin : g_db
        logic [DB_W-1:0] r_cnt;
        logic            r_db;

        always_ff @(posedge cpu_clk or posedge cpu_rst) begin
            if (cpu_rst) begin
                r_cnt <= '0;
                r_db  <= 1'b0;
            end else if (r_btn_s2[g] == r_db) begin
                r_cnt <= '0;
            end else if (r_cnt == DB_W'(DB_CYCLES - 1)) begin
                r_db  <= r_btn_s2[g];
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end

        assign w_btn_db[g] = r_db;
    end

    always_comb begin
        w_rdata = '0;
        if (hit) begin
            case (w_off)
                OFF_DIG:   w_rdata = r_dig;
                OFF_TIMER: w_rdata = r_timer;
                OFF_LED:   w_rdata = {8'h0, r_led};
                OFF_SW:    w_rdata = {8'h0, r_sw_s2};
                OFF_BTN:   w_rdata = {27'h0, w_btn_db};
                default:   w_rdata = '0;
            endcase
        end
    end

    assign rdata = w_rdata;
    assign led   = r_led;

    seg7_scan #(
        .SCAN_DIV (SCAN_DIV)
    ) u_scan (
        .clk      (cpu_clk),
        .rst      (cpu_rst),
        .i_dig    (r_dig),
        .o_dig_en (dig_en),
        .o_seg    (w_seg),
        .o_dp     (DN_DP)
    );

    assign {DN_G, DN_F, DN_E, DN_D, DN_C, DN_B, DN_A} = w_seg;

endmodule
